dmem_lock_arbiter: RTL and testbench
====================================

Name: dmem_lock_arbiter

Overview:
- Shares a single data-memory port between two requesters: core 0 and core 1, each with a pipeline MEM stage and an AMO sequencer.
- Enforces word-address locks taken by atomic read-modify-write sequences. While one requester holds a lock, the other requester cannot touch that word.
- Round-robin arbitration among eligible requests; one outstanding memory transaction at a time.
- Sits between the per-core MEM/AMO logic and the shared dmem/cache interface.

Parameters:
- NUM_REQ, 2, number of requesters; only 2 is supported.
- LOCK_TIMEOUT, 64, idle cycles after which a held lock is forcibly released.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid; held until the matching resp
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  access takes or keeps the lock on its word
- req_addr  in  NUM_REQ*32  byte addresses, requester i at [32i+31:32i]
- req_wdata  in  NUM_REQ*32  write data
- req_wmask  in  NUM_REQ*4  byte enables
- resp  out  NUM_REQ  one-cycle completion pulse per requester
- rdata  out  32  read data, valid with resp
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory byte enables
- mem_resp  in  1  memory completion
- mem_rdata  in  32  memory read data
- lock_valid  out  1  a lock is held
- lock_owner  out  1  index of the lock holder
- lock_addr  out  30  locked word address (addr[31:2])

Behaviour:
- Reset is synchronous (rst on clk). Reset values: state = IDLE; all mem_* outputs = 0; resp = 0; rdata = 0; lock_valid = 0; lock_owner = 0; lock_addr = 0; rr pointer = 0; timeout counter = 0.
- States:
  - IDLE: no transaction in flight.
  - BUSY: a transaction has been issued and the arbiter waits for mem_resp.
- Eligibility: req i is eligible if req_valid[i] is set, and it is not the case that lock_valid is set with lock_owner != i and req_addr_i[31:2] == lock_addr.
- IDLE:
  - Choose among eligible requests. If both are eligible, the requester at the rr pointer wins.
  - On the clock edge, latch the winner's index, we, lock, addr, wdata and wmask into registers, then go to BUSY.
  - Flip the rr pointer to the other requester after every grant.
  - If nothing is eligible, stay in IDLE.
- BUSY:
  - mem_read = !we_q and mem_write = we_q, both driven from the latched registers.
  - mem_addr, mem_wdata and mem_wmask come from the latched registers, with no combinational path from req_*.
  - Hold all of these until mem_resp.
- Response cycle (mem_resp seen in BUSY):
  - resp[owner_q] = 1 combinationally; rdata = mem_rdata; return to IDLE.
  - Minimum latency: request visible in cycle N, strobe in N+1, resp in the same cycle as mem_resp. Next grant no earlier than the cycle after resp.
- Requester rule: drop or change req_* at the edge where resp is seen. The arbiter never double-issues.
- Lock update on a response:
  - If lock_q is set: set lock_valid, lock_owner = owner_q, lock_addr = addr_q[31:2], and clear the timeout counter.
  - If lock_q is clear and owner_q == lock_owner and lock_valid is set: clear lock_valid. This is the release store.
  - Accesses by the owner to other addresses with lock_q clear also release the lock.
- Timeout:
  - While lock_valid is set and the state is not BUSY for the owner, the counter increments every cycle.
  - When the counter reaches LOCK_TIMEOUT - 1, clear lock_valid and reset the counter.
  - Timeout has priority below a same-cycle lock set.
- Non-owner requests to unlocked addresses proceed normally while a lock is held.
- The owner is never blocked by its own lock.
- Simultaneous requests to the same unlocked word: rr decides. The loser waits, and if the winner locks, the loser stays blocked.
- Reset mid-BUSY: the transaction is abandoned; no resp is issued and the lock is cleared.

Decomposition:
- Package dmem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY};
  - constant NUM_REQ_MAX = 2;
  - struct mem_req_t {we, lock, addr[31:0], wdata[31:0], wmask[3:0]}, used for the latched request.
- Sub-module rr_arbiter2: inputs eligible[1:0] and ptr; outputs grant_valid and grant_idx; purely combinational.

Test Plan:
- Single read: req_valid = 01, addr 0x1000, mem_resp 3 cycles later with rdata 0xDEADBEEF -> mem_read high in cycles N+1..N+3, resp = 01 with rdata 0xDEADBEEF, mem_addr 0x1000.
- Contention: both requesters read, addrs 0x100 and 0x200, rr = 0 -> req 0 served first, then req 1; repeat with both still valid -> order alternates 0,1,0,1.
- Lock block: req 0 locked read of 0x2000 completes; req 1 reads 0x2000 -> no grant to req 1 until req 0 writes 0x2000 with lock = 0; then req 1 is granted; lock_valid goes 1 -> 0.
- Lock non-interference: with req 0 holding the lock on 0x2000, req 1 writes 0x3004 -> granted immediately.
- Timeout: req 0 takes the lock, then stays idle with LOCK_TIMEOUT = 8 -> lock_valid drops after 8 cycles and a blocked req 1 to the same word is granted.
- Reset mid-op: rst asserted while BUSY before mem_resp -> the next cycle shows all outputs at 0, state IDLE, no resp pulse, lock_valid = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-requester dmem lock arbiter.
// Holds the FSM state enum and the latched request bundle.
package dmem_arb_pkg;

  localparam int NUM_REQ_MAX = 2;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_req_t;

endpackage

// File: rtl/dmem_lock_arbiter_rr.sv
// Two-way round-robin pick: eligible[1:0], ptr in; grant_valid, grant_idx out.
// When both are eligible the requester at ptr wins.
module rr_arbiter2 (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |eligible;
  assign grant_idx   = (&eligible) ? ptr : eligible[1];

endmodule

// File: rtl/dmem_lock_arbiter.sv
// Shares one dmem port between two requesters with word-address locks.
// Ports: req_* per requester, resp/rdata back, mem_* to dmem, lock_* status.
module dmem_lock_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_wmask,
  output logic [NUM_REQ-1:0]    resp,
  output logic [31:0]           rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_resp,
  input  logic [31:0]           mem_rdata,
  output logic                  lock_valid,
  output logic                  lock_owner,
  output logic [29:0]           lock_addr
);

  localparam int CW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(LOCK_TIMEOUT - 1);

  arb_state_t    state;
  mem_req_t      q;
  mem_req_t      sel;
  logic          owner_q;
  logic          ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    elig;
  logic          hit0;
  logic          hit1;
  logic          gvalid;
  logic          gidx;
  logic          busy;
  logic          done;

  // A requester is blocked only by a lock the other side holds on its word.
  assign hit0 = lock_valid & lock_owner
              & (req_addr[31:2] == lock_addr);
  assign hit1 = lock_valid & ~lock_owner
              & (req_addr[63:34] == lock_addr);
  assign elig = {req_valid[1] & ~hit1,
                 req_valid[0] & ~hit0};

  rr_arbiter2 u_rr (
    .eligible    (elig),
    .ptr         (ptr),
    .grant_valid (gvalid),
    .grant_idx   (gidx)
  );

  always_comb begin
    sel       = '0;
    sel.we    = req_we[gidx];
    sel.lock  = req_lock[gidx];
    sel.addr  = req_addr[32*gidx +: 32];
    sel.wdata = req_wdata[32*gidx +: 32];
    sel.wmask = req_wmask[4*gidx +: 4];
  end

  assign busy = (state == BUSY);
  assign done = busy & mem_resp;

  assign mem_read  = busy & ~q.we;
  assign mem_write = busy & q.we;
  assign mem_addr  = busy ? q.addr  : '0;
  assign mem_wdata = busy ? q.wdata : '0;
  assign mem_wmask = busy ? q.wmask : '0;
  assign resp      = done ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata     = done ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      q          <= '0;
      owner_q    <= 1'b0;
      ptr        <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      lock_addr  <= '0;
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gvalid) begin
            q       <= sel;
            owner_q <= gidx;
            ptr     <= ~gidx;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Lock set wins over release and timeout; the owner's own
      // in-flight access pauses the idle count.
      if (done && q.lock) begin
        lock_valid <= 1'b1;
        lock_owner <= owner_q;
        lock_addr  <= q.addr[31:2];
        cnt        <= '0;
      end else if (done && lock_valid && (owner_q == lock_owner)) begin
        lock_valid <= 1'b0;
        cnt        <= '0;
      end else if (lock_valid && !(busy && (owner_q == lock_owner))) begin
        if (cnt == TMAX) begin
          lock_valid <= 1'b0;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_lock_arbiter.sv
// Bench for dmem_lock_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_lock_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [1:0]  req_lock;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic [1:0]  resp;
  logic [31:0] rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        lock_valid;
  logic        lock_owner;
  logic [29:0] lock_addr;

  always #5 clk = ~clk;

  dmem_lock_arbiter #(
    .NUM_REQ      (2),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .resp       (resp),
    .rdata      (rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .lock_addr  (lock_addr)
  );

  int vectors     = 0;
  int miscompares = 0;

  // What each requester currently wants.
  bit          rv  [2];
  bit          rwe [2];
  bit          rlk [2];
  logic [31:0] ra  [2];
  logic [31:0] rwd [2];
  logic [3:0]  rwm [2];

  // Reference model: one in-flight transaction plus a lock record.
  bit          m_busy;
  int          m_owner;
  bit          t_we;
  bit          t_lock;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [3:0]  t_wmask;
  bit          m_lv;
  int          m_lo;
  logic [29:0] m_la;
  int          m_idle;
  int          m_rr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit elig(input int i);
    return rv[i] && !(m_lv && m_lo != i && ra[i][31:2] == m_la);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; t_we = 0; t_lock = 0;
    t_addr = '0; t_wdata = '0; t_wmask = '0;
    m_lv = 0; m_lo = 0; m_la = '0; m_idle = 0; m_rr = 0;
  endtask

  // One clock cycle: drive, check comb outputs, clock, advance model.
  task automatic step(input bit r, input bit mr, input logic [31:0] md);
    bit done;
    int win;
    bit e0;
    bit e1;
    rst       = r;
    mem_resp  = mr;
    mem_rdata = md;
    for (int i = 0; i < 2; i++) begin
      req_valid[i]         = rv[i];
      req_we[i]            = rwe[i];
      req_lock[i]          = rlk[i];
      req_addr[32*i +: 32] = ra[i];
      req_wdata[32*i +: 32] = rwd[i];
      req_wmask[4*i +: 4]  = rwm[i];
    end
    #1;
    done = m_busy && mr;
    chk("mem_read", 32'(mem_read), 32'(m_busy && !t_we));
    chk("mem_write", 32'(mem_write), 32'(m_busy && t_we));
    chk("mem_addr", mem_addr, m_busy ? t_addr : 32'h0);
    chk("mem_wdata", mem_wdata, m_busy ? t_wdata : 32'h0);
    chk("mem_wmask", 32'(mem_wmask), m_busy ? 32'(t_wmask) : 32'h0);
    chk("resp", 32'(resp), done ? (32'h1 << m_owner) : 32'h0);
    chk("rdata", rdata, done ? md : 32'h0);
    chk("lock_valid", 32'(lock_valid), 32'(m_lv));
    chk("lock_owner", 32'(lock_owner), 32'(m_lo));
    chk("lock_addr", 32'(lock_addr), 32'(m_la));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      e0 = elig(0);
      e1 = elig(1);
      if (e0 && e1) win = m_rr;
      else if (e0)  win = 0;
      else if (e1)  win = 1;
      else          win = -1;
      if (done && t_lock) begin
        m_lv = 1; m_lo = m_owner; m_la = t_addr[31:2]; m_idle = 0;
      end else if (done && m_lv && m_owner == m_lo) begin
        m_lv = 0; m_idle = 0;
      end else if (m_lv && !(m_busy && m_owner == m_lo)) begin
        if (m_idle == TO - 1) begin
          m_lv = 0; m_idle = 0;
        end else begin
          m_idle++;
        end
      end
      if (done) begin
        rv[m_owner] = 0;
        m_busy = 0;
      end else if (!m_busy && win >= 0) begin
        m_busy = 1; m_owner = win; m_rr = 1 - win;
        t_we = rwe[win]; t_lock = rlk[win]; t_addr = ra[win];
        t_wdata = rwd[win]; t_wmask = rwm[win];
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit we, input bit lk,
                         input logic [31:0] a);
    rv[i] = 1; rwe[i] = we; rlk[i] = lk; ra[i] = a;
    rwd[i] = $urandom; rwm[i] = 4'($urandom);
  endtask

  initial begin
    bit mr;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rwe[i] = 0; rlk[i] = 0;
      ra[i] = '0; rwd[i] = '0; rwm[i] = '0;
    end
    model_reset();
    rst = 1; mem_resp = 0; mem_rdata = '0;
    req_valid = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; req_wmask = '0;
    @(negedge clk);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Single read with three-cycle memory latency.
    set_req(0, 0, 0, 32'h1000);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'hDEADBEEF);
    step(0, 0, 0);

    // Contention from a fresh pointer: order must alternate.
    step(1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (!rv[0]) set_req(0, 0, 0, 32'h100);
      if (!rv[1]) set_req(1, 0, 0, 32'h200);
      step(0, 0, 0);
      step(0, 1, $urandom);
    end
    rv[0] = 0; rv[1] = 0;
    step(0, 0, 0);

    // Lock, non-interference, blocking, release store.
    step(1, 0, 0);
    set_req(0, 0, 1, 32'h2000);
    step(0, 0, 0);
    step(0, 1, $urandom);
    set_req(1, 1, 0, 32'h3004);
    step(0, 0, 0);
    step(0, 1, 0);
    set_req(1, 0, 0, 32'h2002);
    step(0, 1, 0);
    step(0, 1, 0);
    set_req(0, 1, 0, 32'h2000);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, $urandom);
    step(0, 0, 0);

    // Timeout frees a word another requester is waiting on.
    step(1, 0, 0);
    set_req(0, 0, 1, 32'h2000);
    step(0, 0, 0);
    step(0, 1, $urandom);
    set_req(1, 0, 0, 32'h2000);
    for (int k = 0; k < 10; k++) step(0, 0, 0);
    step(0, 1, $urandom);
    step(0, 0, 0);

    // Reset while a locked access is in flight.
    set_req(0, 0, 1, 32'h2000);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    rv[0] = 0;
    step(0, 1, 32'h1234);
    step(0, 0, 0);

    // Random traffic over a few neighbouring words.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom), $urandom_range(0, 3) == 0,
                  32'h2000 + 32'($urandom_range(0, 15)));
      end
      mr = m_busy ? ($urandom_range(0, 2) == 0)
                  : ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) step(1, 0, 0);
      else step(0, mr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
